dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the DM_CS / DM_W / DM_R control lines driven by the CPU control unit.
- Accepts one word read or write per request and returns read data after a configurable wait latency.
- Completion is signalled by a one-cycle ack.
- Replaces the ideal zero-wait data memory, so the datapath can be exercised against a slow memory as groundwork for multi-cycle control.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from the request-sampling edge to the ack cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dm_cs  in  1  request strobe (chip select).
- dm_w  in  1  write request qualifier.
- dm_r  in  1  read request qualifier.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in WAIT.
- err  out  1  qualifies ack; the request was rejected.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, rdata=0, ack=0, busy=0, err=0, counter=0.
  - Memory array contents are not cleared.
  - Reset during WAIT aborts the transaction; a pending write is never committed.
  - Reset has priority over every other event.
- States: IDLE, WAIT, ACK. Outputs are registered; ack=1 only in ACK, busy=1 only in WAIT.
- IDLE:
  - If dm_cs=0, stay in IDLE.
  - If dm_cs=1, capture addr, wdata and op into holding registers, then validate.
  - A valid request has exactly one of dm_w/dm_r high, addr[1:0]==0 and addr[31:2] < DEPTH_WORDS.
  - Valid request -> WAIT, counter=LATENCY-1.
  - Invalid request -> ACK with err=1. No array access; rdata keeps its old value.
- WAIT:
  - Inputs are ignored; only the captured values are used.
  - counter!=0 -> decrement.
  - counter==0 -> perform the access:
    - Write: array[addr_q[31:2]] <= wdata_q; rdata unchanged.
    - Read: rdata <= array[addr_q[31:2]].
    - Go to ACK with err=0.
- ACK:
  - Lasts one cycle, then IDLE.
  - dm_cs in the ACK cycle is ignored.
- Timing:
  - Valid request sampled at edge k -> ack=1 during the cycle after edge k+LATENCY.
  - An invalid request acks in the cycle after edge k.
- Back-to-back requests:
  - If the initiator holds dm_cs high through ACK, IDLE samples it at the next edge and starts a new transaction.
  - Minimum spacing between requests is therefore LATENCY+2 edges.
- Index width is log2(DEPTH_WORDS). Upper address bits above the index are checked for the range test, never truncated silently.
- Read-after-write to the same word in consecutive transactions returns the newly written value.

Decomposition:
- Package dmem_pkg holds:
  - State enum (IDLE, WAIT, ACK).
  - Op encoding (OP_RD, OP_WR).
  - Address-alignment constant WORD_BYTES=4.
  - Function clog2 for the index width.
- Sub-module dmem_array:
  - Single-port DEPTH_WORDS x 32 storage.
  - Synchronous write enable, combinational read.
  - The responder registers the read into rdata.

Test Plan:
1. Write then read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF; ack in the cycle after edge k+2, err=0. Read addr=0x10 -> rdata=0xDEADBEEF with ack, busy high for exactly 2 cycles each.
2. Misaligned and out-of-range requests:
   - Read addr=0x13 -> ack+err the cycle after sampling, rdata unchanged, array unchanged.
   - Write addr=0x1000 (DEPTH_WORDS=1024) -> err=1, no write.
3. Illegal qualifiers: dm_cs=1 with dm_w=dm_r=1, and with dm_w=dm_r=0 -> err=1 ack pulse, no access.
4. Reset mid-write: issue write addr=0x20, wdata=0x12345678; assert rst in the first WAIT cycle. Outputs are all 0 next cycle; a subsequent read of 0x20 returns the prior value (0xAAAA5555 preloaded).
5. Held dm_cs: keep a read to 0x10 asserted for 10 cycles with LATENCY=1. Ack pulses occur every 3 cycles; inputs changed during WAIT have no effect on the captured address.
6. LATENCY=1 and LATENCY=15 builds: measured edge-to-ack distance equals LATENCY. Writes to the last word (0xFFC) read back correctly.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
// Holds the FSM state encoding, op encoding and index-width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned WORD_BYTES = 4;

  // Never returns 0 so a one-word array still gets a legal index port.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one word read/write per request, completion
// acknowledged after LATENCY cycles (or immediately with err for bad requests).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_cs,
  input  logic        dm_w,
  input  logic        dm_r,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IDX_W    = clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t           state, state_next;
  logic [3:0]       count, count_next;
  logic             err_next;
  logic             req_valid;
  logic             access;
  logic             mem_we;
  logic [31:0]      mem_rdata;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  op_t              op_q;

  // Full 30-bit word index is compared so high address bits are never aliased.
  assign req_valid = (dm_w ^ dm_r)
                   && ((addr & 32'(WORD_BYTES - 1)) == '0)
                   && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));

  assign access = (state == WAIT) && (count == '0);
  // Gating with rst keeps an aborted write from landing in the array.
  assign mem_we = access && (op_q == OP_WR) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      err   <= err_next;
      if (access && (op_q == OP_RD)) rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE) && dm_cs) begin
      idx_q   <= addr[IDX_W+1:2];
      wdata_q <= wdata;
      op_q    <= dm_w ? OP_WR : OP_RD;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = err;
    case (state)
      IDLE: begin
        if (dm_cs) begin
          if (req_valid) begin
            state_next = WAIT;
            count_next = CNT_INIT;
            err_next   = 1'b0;
          end else begin
            state_next = ACK;
            err_next   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (count != '0) begin
          count_next = count - 4'd1;
        end else begin
          state_next = ACK;
          err_next   = 1'b0;
        end
      end
      ACK: begin
        state_next = IDLE;
        err_next   = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == ACK);
    busy = (state == WAIT);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 2, 1, 15) checked against
// a word-level memory model and the request timing rules.
module tb_dmem_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        cs    [NDUT];
  logic        w     [NDUT];
  logic        r     [NDUT];
  logic [31:0] a     [NDUT];
  logic [31:0] wd    [NDUT];
  logic [31:0] rd    [NDUT];
  logic        ack   [NDUT];
  logic        busy  [NDUT];
  logic        err   [NDUT];

  int          lat [NDUT] = '{2, 1, 15};
  logic [31:0] mdl   [NDUT][DEPTH];
  bit          known [NDUT][DEPTH];
  logic [31:0] exp_rd   [NDUT];
  bit          rd_known [NDUT];

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .dm_cs(cs[0]), .dm_w(w[0]), .dm_r(r[0]), .addr(a[0]),
    .wdata(wd[0]), .rdata(rd[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .dm_cs(cs[1]), .dm_w(w[1]), .dm_r(r[1]), .addr(a[1]),
    .wdata(wd[1]), .rdata(rd[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) dut2 (
    .clk(clk), .rst(rst), .dm_cs(cs[2]), .dm_w(w[2]), .dm_r(r[2]), .addr(a[2]),
    .wdata(wd[2]), .rdata(rd[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]));

  always #5 clk = ~clk;

  function automatic bit req_ok(input bit wr, input bit rdq, input logic [31:0] ad);
    return (wr != rdq) && (ad % 4 == 0) && (ad / 4 < DEPTH);
  endfunction

  // One complete request; measures edges from the sampling edge to the ack cycle.
  task automatic run_req(input int d, input bit wr, input bit rdq,
                         input logic [31:0] ad, input logic [31:0] data, input string tag);
    int n, busy_cnt, exp_lat;
    bit ok;
    ok = req_ok(wr, rdq, ad);
    exp_lat = ok ? lat[d] : 0;
    @(negedge clk);
    cs[d] = 1'b1; w[d] = wr; r[d] = rdq; a[d] = ad; wd[d] = data;
    @(posedge clk);
    #1;
    cs[d] = 1'b0; w[d] = $urandom_range(0, 1); r[d] = $urandom_range(0, 1);
    a[d] = $urandom; wd[d] = $urandom;
    n = 0; busy_cnt = 0;
    while (ack[d] !== 1'b1 && n < 40) begin
      if (busy[d] === 1'b1) busy_cnt++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== exp_lat) begin
      failures++;
      $display("FAIL %s[dut%0d] latency: got %0d expected %0d", tag, d, n, exp_lat);
    end
    checks++;
    if (err[d] !== !ok) begin
      failures++;
      $display("FAIL %s[dut%0d] err: got %b expected %b", tag, d, err[d], !ok);
    end
    checks++;
    if (busy_cnt !== exp_lat) begin
      failures++;
      $display("FAIL %s[dut%0d] busy_cycles: got %0d expected %0d", tag, d, busy_cnt, exp_lat);
    end
    if (ok && rdq) begin
      rd_known[d] = known[d][ad / 4];
      exp_rd[d]   = mdl[d][ad / 4];
    end
    if (ok && wr) begin
      mdl[d][ad / 4]   = data;
      known[d][ad / 4] = 1'b1;
    end
    if (rd_known[d]) begin
      checks++;
      if (rd[d] !== exp_rd[d]) begin
        failures++;
        $display("FAIL %s[dut%0d] rdata: got %h expected %h", tag, d, rd[d], exp_rd[d]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ack[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s[dut%0d] ack_one_cycle: got %b expected 0", tag, d, ack[d]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({rd[d], ack[d], busy[d], err[d]} !== 35'd0) begin
        failures++;
        $display("FAIL reset[dut%0d]: got rdata=%h ack=%b busy=%b err=%b expected all 0",
                 d, rd[d], ack[d], busy[d], err[d]);
      end
      exp_rd[d] = '0; rd_known[d] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    run_req(0, 1, 0, 32'h10, 32'hDEADBEEF, "wr_10");
    run_req(0, 0, 1, 32'h10, 32'h0, "rd_10");
    run_req(0, 1, 0, 32'h0, 32'h0BADF00D, "wr_0");
  endtask

  task automatic test_bad_requests();
    run_req(0, 0, 1, 32'h13, 32'h0, "rd_misaligned");
    run_req(0, 1, 0, 32'h1000, 32'h55555555, "wr_out_of_range");
    run_req(0, 1, 0, 32'h8000_0010, 32'h66666666, "wr_high_bits");
    run_req(0, 1, 1, 32'h10, 32'h77777777, "both_qualifiers");
    run_req(0, 0, 0, 32'h10, 32'h88888888, "no_qualifier");
    run_req(0, 0, 1, 32'h0, 32'h0, "rd_0_untouched");
    run_req(0, 0, 1, 32'h10, 32'h0, "rd_10_untouched");
  endtask

  task automatic test_reset_mid_write();
    for (int d = 0; d < 2; d++) begin
      run_req(d, 1, 0, 32'h20, 32'hAAAA5555, "preload_20");
      run_req(d, 0, 1, 32'h20, 32'h0, "rd_20_before");
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b1; w[d] = 1'b1; r[d] = 1'b0; a[d] = 32'h20; wd[d] = 32'h12345678;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) cs[d] = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rd[d], ack[d], busy[d], err[d]} !== 35'd0) begin
        failures++;
        $display("FAIL reset_mid_write[dut%0d]: got rdata=%h ack=%b busy=%b err=%b expected all 0",
                 d, rd[d], ack[d], busy[d], err[d]);
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      exp_rd[d] = '0; rd_known[d] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) run_req(d, 0, 1, 32'h20, 32'h0, "rd_20_after_abort");
  endtask

  // Read held asserted on the LATENCY=1 build; address is disturbed outside IDLE.
  task automatic test_held_cs();
    int period;
    period = lat[1] + 2;
    run_req(1, 1, 0, 32'h10, 32'hC0FFEE01, "preload_10");
    run_req(1, 1, 0, 32'h30, 32'h30303030, "preload_30");
    @(negedge clk);
    cs[1] = 1'b1; w[1] = 1'b0; r[1] = 1'b1; a[1] = 32'h10;
    @(posedge clk);
    for (int j = 0; j < 12; j++) begin
      #1;
      checks++;
      if (ack[1] !== (j % period == period - 2)) begin
        failures++;
        $display("FAIL held_cs_ack[cycle %0d]: got %b expected %b", j, ack[1], (j % period == period - 2));
      end
      checks++;
      if (busy[1] !== (j % period < period - 2)) begin
        failures++;
        $display("FAIL held_cs_busy[cycle %0d]: got %b expected %b", j, busy[1], (j % period < period - 2));
      end
      if (j % period == period - 2) begin
        checks++;
        if (rd[1] !== mdl[1][4]) begin
          failures++;
          $display("FAIL held_cs_rdata[cycle %0d]: got %h expected %h", j, rd[1], mdl[1][4]);
        end
      end
      cs[1] = (j < 9);
      a[1]  = (j % period == period - 1) ? 32'h10 : 32'h30;
      @(posedge clk);
    end
    #1;
    exp_rd[1] = mdl[1][4]; rd_known[1] = known[1][4];
  endtask

  task automatic test_latency_bounds();
    for (int d = 1; d < NDUT; d++) begin
      run_req(d, 1, 0, 32'h0, $urandom, "edge_wr_0");
      run_req(d, 1, 0, 32'hFFC, $urandom, "edge_wr_last");
      run_req(d, 1, 0, 32'h1000, $urandom, "edge_wr_oor");
      run_req(d, 0, 1, 32'h0, 32'h0, "edge_rd_0");
      run_req(d, 0, 1, 32'hFFC, 32'h0, "edge_rd_last");
    end
  endtask

  task automatic test_random();
    int sel, op;
    logic [31:0] ad;
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 16; k++) run_req(d, 1, 0, 32'(k * 4), $urandom, "rand_preload");
      for (int k = 0; k < 15; k++) begin
        sel = $urandom_range(0, 9);
        op  = $urandom_range(0, 5);
        if (sel <= 6)      ad = 32'($urandom_range(0, 15) * 4);
        else if (sel == 7) ad = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (sel == 8) ad = 32'h1000 + 32'($urandom_range(0, 4095) * 4);
        else               ad = 32'h8000_0000 | 32'($urandom_range(0, 15) * 4);
        run_req(d, (op == 2 || op == 3 || op == 4), (op <= 1 || op == 4), ad, $urandom, "rand");
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      cs[d] = 1'b0; w[d] = 1'b0; r[d] = 1'b0; a[d] = '0; wd[d] = '0;
      exp_rd[d] = '0; rd_known[d] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mdl[d][i] = '0; known[d][i] = 1'b0;
      end
    end
    test_reset();
    test_write_read();
    test_bad_requests();
    test_reset_mid_write();
    test_held_cs();
    test_latency_bounds();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
